spi_flash_responder: RTL and testbench

- SPI target that emulates the subset of a serial NOR flash that the bootloader's SPI master uses.
- Lets the bootloader be exercised on-chip, or against a second FPGA, with no physical flash.
- Oversamples CS/SCK/MOSI in the clk_48mhz domain, decodes the command, and streams data from a byte-wide memory port over MISO.
- Sits between board pins and an on-chip BRAM/ROM.

---
 rtl/spi_flash_responder_if.sv | 15 +
 rtl/spi_flash_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
`default_nettype none
// =============================================================================
// spi_flash_responder_if : byte-wide read port between the responder and memory
// Rev 1.0
// =============================================================================
interface spi_flash_responder_if;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// =============================================================================
// spi_flash_responder : SPI mode-0 target emulating a read-only NOR flash subset
// Rev 1.0
// =============================================================================
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter logic [7:0]  STATUS_VAL  = 8'h00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    input  logic                  spi_cs,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    spi_flash_responder_if.master mem,
    output logic                  powered_down,
    output logic                  cmd_valid,
    output logic [7:0]            cmd_byte,
    output logic                  err_underrun
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ID_OUT, S_STAT_OUT, S_ADDR, S_READ, S_IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_last_q, sck_last_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [22:0]            rx_q, rx_d;
    logic [6:0]             tx_q, tx_d;
    logic [1:0]             id_idx_q, id_idx_d;
    logic                   pending_q, pending_d;
    logic                   have_data_q, have_data_d;
    logic [7:0]             data_q, data_d;
    logic                   arm_pd_q, arm_pd_d;
    logic                   arm_rel_q, arm_rel_d;
    logic                   extra_q, extra_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   mem_req_q, mem_req_d;
    logic [23:0]            mem_addr_q, mem_addr_d;
    logic                   powered_down_q, powered_down_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_byte_q, cmd_byte_d;
    logic                   err_underrun_q, err_underrun_d;

    logic        cs_s, sck_s, mosi_s, sck_rise, sck_fall, byte_ready;
    logic [23:0] rx_next;
    logic [7:0]  rd_byte, load_byte;

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_last_q;
    assign sck_fall   = ~sck_s & sck_last_q;
    assign rx_next    = {rx_q, mosi_s};
    // Data acked in the load cycle itself is used directly rather than reported as an underrun.
    assign byte_ready = have_data_q | (pending_q & mem.mem_ack);
    assign rd_byte    = have_data_q ? data_q : mem.mem_data;

    always_comb begin
        state_d        = state_q;
        cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        sck_sync_d     = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_last_d     = sck_s;
        bit_cnt_d      = bit_cnt_q;
        rx_d           = rx_q;
        tx_d           = tx_q;
        id_idx_d       = id_idx_q;
        pending_d      = pending_q;
        have_data_d    = have_data_q;
        data_d         = data_q;
        arm_pd_d       = arm_pd_q;
        arm_rel_d      = arm_rel_q;
        extra_d        = extra_q;
        miso_d         = miso_q;
        oe_d           = oe_q;
        mem_req_d      = 1'b0;
        mem_addr_d     = mem_addr_q;
        powered_down_d = powered_down_q;
        cmd_valid_d    = 1'b0;
        cmd_byte_d     = cmd_byte_q;
        err_underrun_d = 1'b0;
        load_byte      = 8'hFF;

        if (pending_q && mem.mem_ack) begin
            data_d      = mem.mem_data;
            have_data_d = 1'b1;
            pending_d   = 1'b0;
        end

        if (cs_s) begin
            if (state_q != S_IDLE) begin
                if (arm_pd_q && !extra_q) powered_down_d = 1'b1;
                if (arm_rel_q)            powered_down_d = 1'b0;
            end
            state_d     = S_IDLE;
            bit_cnt_d   = 5'd0;
            oe_d        = 1'b0;
            miso_d      = 1'b1;
            pending_d   = 1'b0;
            have_data_d = 1'b0;
            arm_pd_d    = 1'b0;
            arm_rel_d   = 1'b0;
            extra_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = 5'd0;
                end
                S_CMD: if (sck_rise) begin
                    rx_d      = rx_next[22:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d   = 5'd0;
                        cmd_valid_d = 1'b1;
                        cmd_byte_d  = rx_next[7:0];
                        id_idx_d    = 2'd0;
                        state_d     = S_IGNORE;
                        if (rx_next[7:0] == 8'hAB) begin
                            arm_rel_d = 1'b1;
                        end else if (!powered_down_q) begin
                            case (rx_next[7:0])
                                8'h9F:   state_d = S_ID_OUT;
                                8'h05:   state_d = S_STAT_OUT;
                                8'h03:   state_d = S_ADDR;
                                8'hB9:   arm_pd_d = 1'b1;
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: if (sck_rise) begin
                    rx_d      = rx_next[22:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d  = 5'd0;
                        mem_addr_d = rx_next;
                        mem_req_d  = 1'b1;
                        pending_d  = 1'b1;
                        state_d    = S_READ;
                    end
                end
                default: if (sck_rise) begin
                    bit_cnt_d = {2'b00, bit_cnt_q[2:0] + 3'd1};
                    if (state_q == S_IGNORE) extra_d = 1'b1;
                end
            endcase

            if (sck_fall && (state_q inside {S_ID_OUT, S_STAT_OUT, S_ADDR, S_READ})) begin
                oe_d = 1'b1;
                if (bit_cnt_q[2:0] == 3'd0) begin
                    case (state_q)
                        S_ID_OUT: begin
                            case (id_idx_q)
                                2'd0:    load_byte = JEDEC_ID[23:16];
                                2'd1:    load_byte = JEDEC_ID[15:8];
                                2'd2:    load_byte = JEDEC_ID[7:0];
                                default: load_byte = 8'hFF;
                            endcase
                            if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
                        end
                        S_STAT_OUT: load_byte = STATUS_VAL;
                        S_READ: begin
                            if (byte_ready) begin
                                load_byte   = rd_byte;
                                have_data_d = 1'b0;
                                pending_d   = 1'b1;
                                mem_req_d   = 1'b1;
                                mem_addr_d  = mem_addr_q + 24'd1;
                            end else begin
                                err_underrun_d = 1'b1;
                            end
                        end
                        default: load_byte = 8'hFF;
                    endcase
                    miso_d = load_byte[7];
                    tx_d   = load_byte[6:0];
                end else begin
                    miso_d = tx_q[6];
                    tx_d   = {tx_q[5:0], 1'b1};
                end
            end
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cs_sync_q      <= '1;
            sck_sync_q     <= '0;
            mosi_sync_q    <= '0;
            sck_last_q     <= 1'b0;
            bit_cnt_q      <= 5'd0;
            rx_q           <= 23'd0;
            tx_q           <= 7'h7F;
            id_idx_q       <= 2'd0;
            pending_q      <= 1'b0;
            have_data_q    <= 1'b0;
            data_q         <= 8'h00;
            arm_pd_q       <= 1'b0;
            arm_rel_q      <= 1'b0;
            extra_q        <= 1'b0;
            miso_q         <= 1'b1;
            oe_q           <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 24'd0;
            powered_down_q <= 1'b0;
            cmd_valid_q    <= 1'b0;
            cmd_byte_q     <= 8'h00;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cs_sync_q      <= cs_sync_d;
            sck_sync_q     <= sck_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            sck_last_q     <= sck_last_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_q           <= rx_d;
            tx_q           <= tx_d;
            id_idx_q       <= id_idx_d;
            pending_q      <= pending_d;
            have_data_q    <= have_data_d;
            data_q         <= data_d;
            arm_pd_q       <= arm_pd_d;
            arm_rel_q      <= arm_rel_d;
            extra_q        <= extra_d;
            miso_q         <= miso_d;
            oe_q           <= oe_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            powered_down_q <= powered_down_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_byte_q     <= cmd_byte_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    assign spi_miso     = miso_q;
    assign spi_miso_oe  = oe_q;
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign powered_down = powered_down_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_byte     = cmd_byte_q;
    assign err_underrun = err_underrun_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// =============================================================================
// tb_spi_flash_responder : directed SPI master + memory model for the responder
// Rev 1.0
// =============================================================================
module tb_spi_flash_responder;
    localparam int H    = 6;   // SCK half period in clk_48mhz cycles
    localparam int SYNC = 2;

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b0;
    logic       spi_cs    = 1'b1;
    logic       spi_sck   = 1'b0;
    logic       spi_mosi  = 1'b0;
    logic       spi_miso, spi_miso_oe, powered_down, cmd_valid, err_underrun;
    logic [7:0] cmd_byte;

    spi_flash_responder_if mif();

    spi_flash_responder #(
        .JEDEC_ID   (24'hEF4016),
        .STATUS_VAL (8'h00),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .spi_cs      (spi_cs),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem         (mif.master),
        .powered_down(powered_down),
        .cmd_valid   (cmd_valid),
        .cmd_byte    (cmd_byte),
        .err_underrun(err_underrun)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    // Memory model: data byte equals the low address byte, ack ack_delay cycles after req.
    int          ack_delay = 1;
    int          m_cnt     = 0;
    logic [23:0] m_addr    = 24'd0;
    logic [23:0] req_log [0:63];
    int          req_n     = 0;

    always @(posedge clk_48mhz) begin
        mif.mem_ack <= 1'b0;
        if (mif.mem_req === 1'b1) begin
            req_log[req_n % 64] <= mif.mem_addr;
            req_n <= req_n + 1;
            if (ack_delay <= 1) begin
                mif.mem_ack  <= 1'b1;
                mif.mem_data <= mif.mem_addr[7:0];
                m_cnt        <= 0;
            end else begin
                m_cnt  <= ack_delay - 1;
                m_addr <= mif.mem_addr;
            end
        end else if (m_cnt > 0) begin
            if (m_cnt == 1) begin
                mif.mem_ack  <= 1'b1;
                mif.mem_data <= m_addr[7:0];
            end
            m_cnt <= m_cnt - 1;
        end
    end

    int err_cnt = 0, cv_cnt = 0, oe_cnt = 0;
    always @(posedge clk_48mhz) begin
        if (err_underrun === 1'b1) err_cnt <= err_cnt + 1;
        if (cmd_valid === 1'b1)    cv_cnt  <= cv_cnt + 1;
        if (spi_miso_oe === 1'b1)  oe_cnt  <= oe_cnt + 1;
    end

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] rx;
    logic [7:0] rd [0:3];
    int         base, e0, c0, o0;

    task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic half_period();
        repeat (H) @(negedge clk_48mhz);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            spi_mosi = tx[7-i];
            half_period();
            spi_sck = 1'b1;
            r = {r[6:0], spi_miso};
            half_period();
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        half_period();
    endtask

    task automatic cs_high();
        half_period();
        spi_cs = 1'b1;
    endtask

    task automatic gap();
        repeat (10) @(negedge clk_48mhz);
    endtask

    task automatic read_seq(input logic [23:0] addr, input int n);
        logic [7:0] dummy;
        cs_low();
        spi_bits(8'h03, 8, dummy);
        spi_bits(addr[23:16], 8, dummy);
        spi_bits(addr[15:8], 8, dummy);
        spi_bits(addr[7:0], 8, dummy);
        for (int i = 0; i < n; i++) spi_bits(8'h00, 8, rd[i]);
        cs_high();
        gap();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_48mhz);
        check_eq("reset_outs",
                 {spi_miso, spi_miso_oe, mif.mem_req, mif.mem_addr, powered_down, cmd_valid, cmd_byte, err_underrun},
                 {1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 8'h00, 1'b0});
        reset = 1'b1;
        repeat (4) @(negedge clk_48mhz);

        // Reset asserted in the middle of a read byte
        cs_low();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h10, 8, rx);
        spi_bits(8'h00, 4, rx);
        spi_sck = 1'b1;
        reset   = 1'b0;
        #1;
        check_eq("midread_reset_outs",
                 {spi_miso, spi_miso_oe, mif.mem_req, mif.mem_addr, powered_down, cmd_valid, cmd_byte, err_underrun},
                 {1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 8'h00, 1'b0});
        spi_sck = 1'b0;
        spi_cs  = 1'b1;
        repeat (3) @(negedge clk_48mhz);
        reset = 1'b1;
        repeat (4) @(negedge clk_48mhz);

        // JEDEC ID with one trailing byte
        c0 = cv_cnt;
        cs_low();
        spi_bits(8'h9F, 8, rx);
        for (int i = 0; i < 4; i++) spi_bits(8'h00, 8, rd[i]);
        check_eq("id_oe_on", {39'd0, spi_miso_oe}, 40'd1);
        cs_high();
        repeat (SYNC + 2) @(negedge clk_48mhz);
        check_eq("id_oe_off", {39'd0, spi_miso_oe}, 40'd0);
        check_eq("id_bytes", {8'h00, rd[0], rd[1], rd[2], rd[3]}, {8'h00, 32'hEF4016FF});
        check_eq("id_cmd_valid", 40'(cv_cnt - c0), 40'd1);
        check_eq("id_cmd_byte", {32'd0, cmd_byte}, {32'd0, 8'h9F});
        gap();

        // Status register
        cs_low();
        spi_bits(8'h05, 8, rx);
        spi_bits(8'h00, 8, rd[0]);
        spi_bits(8'h00, 8, rd[1]);
        cs_high();
        gap();
        check_eq("status_bytes", {24'd0, rd[0], rd[1]}, 40'h0000000000);

        // Read across a 64K boundary
        ack_delay = 1;
        base = req_n;
        e0   = err_cnt;
        read_seq(24'h00FFFE, 4);
        check_eq("rd_bytes", {8'h00, rd[0], rd[1], rd[2], rd[3]}, {8'h00, 32'hFEFF0001});
        check_eq("rd_addr0", {16'd0, req_log[base % 64]}, {16'd0, 24'h00FFFE});
        check_eq("rd_addr1", {16'd0, req_log[(base + 1) % 64]}, {16'd0, 24'h00FFFF});
        check_eq("rd_addr2", {16'd0, req_log[(base + 2) % 64]}, {16'd0, 24'h010000});
        check_eq("rd_addr3", {16'd0, req_log[(base + 3) % 64]}, {16'd0, 24'h010001});
        check_eq("rd_no_underrun", 40'(err_cnt - e0), 40'd0);

        // Address wrap at top of space
        base = req_n;
        read_seq(24'hFFFFFF, 2);
        check_eq("wrap_bytes", {24'd0, rd[0], rd[1]}, {24'd0, 16'hFF00});
        check_eq("wrap_addr1", {16'd0, req_log[(base + 1) % 64]}, {16'd0, 24'h000000});

        // First read acked too late
        ack_delay = 7;
        base = req_n;
        e0   = err_cnt;
        read_seq(24'h000123, 2);
        ack_delay = 1;
        check_eq("late_bytes", {24'd0, rd[0], rd[1]}, {24'd0, 16'hFF23});
        check_eq("late_underrun", 40'(err_cnt - e0), 40'd1);
        check_eq("late_addr1", {16'd0, req_log[(base + 1) % 64]}, {16'd0, 24'h000124});

        // Deep power-down and release
        cs_low();
        spi_bits(8'hB9, 8, rx);
        cs_high();
        gap();
        check_eq("pd_set", {39'd0, powered_down}, 40'd1);

        o0 = oe_cnt;
        c0 = cv_cnt;
        cs_low();
        spi_bits(8'h9F, 8, rx);
        for (int i = 0; i < 3; i++) spi_bits(8'h00, 8, rd[i]);
        cs_high();
        gap();
        check_eq("pd_id_oe_cycles", 40'(oe_cnt - o0), 40'd0);
        check_eq("pd_cmd_valid", 40'(cv_cnt - c0), 40'd1);
        check_eq("pd_still_set", {39'd0, powered_down}, 40'd1);

        cs_low();
        spi_bits(8'hAB, 8, rx);
        cs_high();
        gap();
        check_eq("pd_release", {39'd0, powered_down}, 40'd0);

        c0 = cv_cnt;
        cs_low();
        spi_bits(8'hB9, 5, rx);
        cs_high();
        gap();
        check_eq("pd_partial", {39'd0, powered_down}, 40'd0);
        check_eq("pd_partial_no_cmd", 40'(cv_cnt - c0), 40'd0);

        // Normal ID still works after release
        cs_low();
        spi_bits(8'h9F, 8, rx);
        spi_bits(8'h00, 8, rd[0]);
        cs_high();
        gap();
        check_eq("id_after_release", {32'd0, rd[0]}, {32'd0, 8'hEF});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
